// File: rtl/mem_fill_ctrl.sv
// mem_fill_ctrl: fills a memory range with a constant or arithmetic progression.
// Define MEM_FILL_VERIFY_EN to add a read-back verify pass after the write pass.
module mem_fill_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   count,
  input  logic [DATA_WIDTH-1:0]    fill_data,
  input  logic [DATA_WIDTH-1:0]    fill_step,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  input  logic [DATA_WIDTH-1:0]    mem_dataOut,
  output logic                     verify_err,
  output logic [ADDRESS_WIDTH-1:0] err_addr
);
  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;
`ifdef MEM_FILL_VERIFY_EN
  localparam state_t POST_WRITE = VERIFY;
`else
  localparam state_t POST_WRITE = DONE;
`endif
  localparam logic [ADDRESS_WIDTH:0]   ONE_W = 1;
  localparam logic [ADDRESS_WIDTH-1:0] ONE_A = 1;
  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH:0]   idx_q, idx_d, cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    step_q, step_d, mem_dataIn_q, mem_dataIn_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                     mem_wEn_q, mem_wEn_d;
  logic                     go, last_wr;
`ifdef MEM_FILL_VERIFY_EN
  logic [ADDRESS_WIDTH-1:0] base_q, base_d, err_addr_q, err_addr_d;
  logic [DATA_WIDTH-1:0]    exp_q, exp_d;
  logic                     verify_err_q, verify_err_d;
`endif

  assign go      = state_q == IDLE && start;
  assign last_wr = state_q == WRITE && idx_q + ONE_W == cnt_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? (count == '0 ? DONE : WRITE) : IDLE;
      WRITE:   state_d = last_wr ? POST_WRITE : WRITE;
      VERIFY:  state_d = idx_q == cnt_q ? DONE : VERIFY;
      default: state_d = IDLE;
    endcase
  end

  // Data and expected value advance with running adders; the verify pass
  // rewinds the address to the base and re-walks the same range.
  always_comb begin
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    step_d       = step_q;
    mem_wEn_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_dataIn_d = mem_dataIn_q;
`ifdef MEM_FILL_VERIFY_EN
    base_d       = base_q;
    exp_d        = exp_q;
    verify_err_d = verify_err_q;
    err_addr_d   = err_addr_q;
`endif
    if (go) begin
      idx_d        = '0;
      cnt_d        = count;
      step_d       = fill_step;
      mem_wEn_d    = count != '0;
      mem_addr_d   = base_addr;
      mem_dataIn_d = fill_data;
`ifdef MEM_FILL_VERIFY_EN
      base_d       = base_addr;
      exp_d        = fill_data;
      verify_err_d = 1'b0;
      err_addr_d   = count != '0 ? '0 : err_addr_q;
`endif
    end else if (state_q == WRITE) begin
      idx_d        = last_wr ? '0 : idx_q + ONE_W;
      mem_wEn_d    = !last_wr;
      mem_addr_d   = mem_addr_q + ONE_A;
      mem_dataIn_d = mem_dataIn_q + step_q;
`ifdef MEM_FILL_VERIFY_EN
      if (last_wr) mem_addr_d = base_q;
    end else if (state_q == VERIFY && idx_q != cnt_q) begin
      idx_d      = idx_q + ONE_W;
      mem_addr_d = mem_addr_q + ONE_A;
      exp_d      = exp_q + step_q;
      if (mem_dataOut != exp_q && !verify_err_q) begin
        verify_err_d = 1'b1;
        err_addr_d   = mem_addr_q;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx_q        <= '0;
      cnt_q        <= '0;
      step_q       <= '0;
      mem_wEn_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_dataIn_q <= '0;
`ifdef MEM_FILL_VERIFY_EN
      base_q       <= '0;
      exp_q        <= '0;
      verify_err_q <= 1'b0;
      err_addr_q   <= '0;
`endif
    end else begin
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      mem_wEn_q    <= mem_wEn_d;
      mem_addr_q   <= mem_addr_d;
      mem_dataIn_q <= mem_dataIn_d;
`ifdef MEM_FILL_VERIFY_EN
      base_q       <= base_d;
      exp_q        <= exp_d;
      verify_err_q <= verify_err_d;
      err_addr_q   <= err_addr_d;
`endif
    end

  assign busy       = state_q == WRITE || state_q == VERIFY;
  assign done       = state_q == DONE;
  assign mem_wEn    = mem_wEn_q;
  assign mem_addr   = mem_addr_q;
  assign mem_dataIn = mem_dataIn_q;
`ifdef MEM_FILL_VERIFY_EN
  assign verify_err = verify_err_q;
  assign err_addr   = err_addr_q;
`else
  logic unused_dataout;
  assign unused_dataout = ^mem_dataOut;
  assign verify_err     = 1'b0;
  assign err_addr       = '0;
`endif
endmodule

// File: tb/tb_mem_fill_ctrl.sv
// tb_mem_fill_ctrl: scoreboard bench for mem_fill_ctrl with a negedge word memory model.
// Also covers the MEM_FILL_VERIFY_EN build when that macro is defined.
module tb_mem_fill_ctrl;
`ifdef MEM_FILL_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst, start, busy, done, mem_wEn, verify_err, corrupt;
  logic [11:0] base_addr, mem_addr, err_addr;
  logic [12:0] count;
  logic [31:0] fill_data, fill_step, mem_dataIn, mem_dataOut;
  logic [31:0] mem [4096];
  wr_t         sb[$];
  wr_t         e;
  int          cyc = 0, n_vec = 0, n_err = 0;

  mem_fill_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .fill_data(fill_data), .fill_step(fill_step), .busy(busy), .done(done),
    .mem_wEn(mem_wEn), .mem_addr(mem_addr), .mem_dataIn(mem_dataIn),
    .mem_dataOut(mem_dataOut), .verify_err(verify_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial for (int i = 0; i < 4096; i++) mem[i] <= {20'hA5000, 12'(i)};

  always @(negedge clk) begin
    if (mem_wEn)
      mem[mem_addr] <= (corrupt && (mem_addr == 12'h042 || mem_addr == 12'h044)) ? ~mem_dataIn : mem_dataIn;
    mem_dataOut <= mem[mem_addr];
  end

  always @(negedge clk)
    if (mem_wEn) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL write_unexpected: addr=%h data=%h cyc=%0d", mem_addr, mem_dataIn, cyc);
      end else begin
        e = sb.pop_front();
        if (mem_addr !== e.a || mem_dataIn !== e.d || cyc != e.c || busy !== 1'b1) begin
          n_err++;
          $display("FAIL write: got addr=%h data=%h cyc=%0d busy=%b, expected addr=%h data=%h cyc=%0d busy=1",
                   mem_addr, mem_dataIn, cyc, busy, e.a, e.d, e.c);
        end
      end
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int lat(input int n);
    return n == 0 ? 0 : (VER ? 2 * n + 1 : n);
  endfunction

  task automatic issue(input logic [11:0] b, input logic [12:0] n, input logic [31:0] f,
                       input logic [31:0] s, input int npush, output int p);
    p = cyc + 1;
    for (int i = 0; i < npush; i++) sb.push_back(wr_t'{b + 12'(i), f + s * 32'(i), p + i});
    base_addr = b;
    count     = n;
    fill_data = f;
    fill_step = s;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int p, input int l, input bit poke);
    for (int t = 0; t < l + 20 && !done; t++) @(negedge clk);
    chk({nm, "_done_lat"}, 32'(cyc - p), 32'(l));
    if (poke) begin
      base_addr = 12'h300;
      count     = 13'd2;
      start     = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_done_pulse"}, 32'({busy, done, mem_wEn}), 32'h0);
    chk({nm, "_sb_empty"}, 32'(sb.size()), 32'h0);
  endtask

  initial begin
    int p, w, bad;
    rst = 1'b0; start = 1'b0; corrupt = 1'b0;
    base_addr = '0; count = '0; fill_data = '0; fill_step = '0;
    #3 rst = 1'b1;
    #1;
    chk("reset_ctl", 32'({busy, done, mem_wEn, verify_err}), 32'h0);
    chk("reset_addr", 32'({mem_addr, err_addr}), 32'h0);
    chk("reset_data", mem_dataIn, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    w = 0;
    repeat (20) begin
      @(negedge clk);
      w += int'(mem_wEn);
    end
    chk("idle_no_wen", 32'(w), 32'h0);

    issue(12'h010, 13'd4, 32'hDEADBEEF, 32'h0, 4, p);
    wait_done("const", p, lat(4), 1'b0);
    for (int i = 0; i < 4; i++) chk("const_mem", mem[12'h010 + 12'(i)], 32'hDEADBEEF);
    chk("const_below", mem[12'h00F], 32'hA500000F);
    chk("const_above", mem[12'h014], 32'hA5000014);

    issue(12'hFFE, 13'd4, 32'hFFFFFFFE, 32'h1, 4, p);
    wait_done("wrap", p, lat(4), 1'b0);
    chk("wrap_ffe", mem[12'hFFE], 32'hFFFFFFFE);
    chk("wrap_fff", mem[12'hFFF], 32'hFFFFFFFF);
    chk("wrap_000", mem[12'h000], 32'h00000000);
    chk("wrap_001", mem[12'h001], 32'h00000001);

    issue(12'h020, 13'd0, 32'h12345678, 32'h0, 0, p);
    wait_done("count0", p, 0, 1'b0);
    chk("count0_mem", mem[12'h020], 32'hA5000020);

    issue(12'h200, 13'd6, 32'h00000100, 32'h00000004, 6, p);
    @(negedge clk);
    base_addr = 12'h300; count = 13'd2; fill_data = 32'hBAD0BAD0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", p, lat(6), 1'b1);
    chk("ignore_mem300", mem[12'h300], 32'hA5000300);
    chk("ignore_mem205", mem[12'h205], 32'h00000114);

    issue(12'h100, 13'd8, 32'h11110000, 32'h10, 3, p);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_ctl", 32'({busy, done, mem_wEn}), 32'h0);
    chk("rstmid_bus", 32'({mem_addr, 20'h0}) | mem_dataIn, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_sb", 32'(sb.size()), 32'h0);
    for (int i = 0; i < 3; i++) chk("rstmid_written", mem[12'h100 + 12'(i)], 32'h11110000 + 32'h10 * 32'(i));
    for (int i = 3; i < 8; i++) chk("rstmid_untouched", mem[12'h100 + 12'(i)], {20'hA5000, 12'h100 + 12'(i)});

`ifdef MEM_FILL_VERIFY_EN
    corrupt = 1'b1;
    issue(12'h040, 13'd5, 32'h100, 32'h11, 5, p);
    wait_done("vbad", p, 11, 1'b0);
    chk("vbad_err", 32'(verify_err), 32'h1);
    chk("vbad_addr", 32'(err_addr), 32'h042);
    corrupt = 1'b0;
    issue(12'h040, 13'd5, 32'h100, 32'h11, 5, p);
    wait_done("vclean", p, 11, 1'b0);
    chk("vclean_err", 32'(verify_err), 32'h0);
    chk("vclean_addr", 32'(err_addr), 32'h0);
`endif

    issue(12'h800, 13'd4096, 32'h1000, 32'h3, 4096, p);
    wait_done("full", p, lat(4096), 1'b0);
    bad = 0;
    for (int a = 0; a < 4096; a++)
      if (mem[a] !== 32'h1000 + 32'h3 * 32'((a - 32'h800) & 32'hFFF)) bad++;
    chk("full_mem_bad", 32'(bad), 32'h0);
    chk("full_verify_err", 32'(verify_err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", n_vec, n_err);
    $fatal(1);
  end
endmodule
